// File: rtl/fp_div_issue.sv
// fp_div_issue: issue/response wrapper around an iterative FP divider.
// Accepts one request at a time, pulses the divider start, waits for done
// (or gives up after TIMEOUT_CYCLES), then holds the response until taken.

package fp_div_issue_pkg;

   typedef enum logic [1:0] {
      FP16 = 2'd0,
      FP32 = 2'd1,
      FP64 = 2'd2,
      BF16 = 2'd3
   } fp_format_e;

   typedef enum logic [2:0] {
      RNE = 3'd0,
      RTZ = 3'd1,
      RDN = 3'd2,
      RUP = 3'd3,
      RMM = 3'd4
   } roundmode_e;

   // IEEE exception flags: invalid, divide-by-zero, overflow, underflow, inexact
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   function automatic int fp_width(fp_format_e fmt);
      case (fmt)
         FP16:    return 16;
         FP32:    return 32;
         FP64:    return 64;
         BF16:    return 16;
         default: return 32;
      endcase
   endfunction

   function automatic int fp_exp_width(fp_format_e fmt);
      case (fmt)
         FP16:    return 5;
         FP32:    return 8;
         FP64:    return 11;
         BF16:    return 8;
         default: return 8;
      endcase
   endfunction

endpackage

// Handshakes: req_* transfers on a cycle where req_valid_i && req_ready_o;
// rsp_* transfers on a cycle where rsp_valid_o && rsp_ready_i. A valid, once
// raised, holds its payload stable until the transfer cycle.
module fp_div_issue
   import fp_div_issue_pkg::*;
#(
   parameter fp_format_e FP_FORMAT      = FP32,
   parameter int         TAG_W          = 4,
   // Legal range 2..1023; the wait counter is 10 bits wide.
   parameter int         TIMEOUT_CYCLES = 64,
   localparam int        FP_WIDTH       = fp_width(FP_FORMAT)
) (
   input  logic                clk_i,
   input  logic                reset_i,

   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [FP_WIDTH-1:0] req_a_i,
   input  logic [FP_WIDTH-1:0] req_b_i,
   input  roundmode_e          req_rnd_i,
   input  logic [TAG_W-1:0]    req_tag_i,

   output logic [FP_WIDTH-1:0] div_a_o,
   output logic [FP_WIDTH-1:0] div_b_o,
   output roundmode_e          div_rnd_o,
   output logic                div_start_o,
   input  logic                div_done_i,
   input  logic [FP_WIDTH-1:0] div_result_i,
   input  status_t             div_flags_i,

   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [FP_WIDTH-1:0] rsp_result_o,
   output status_t             rsp_flags_o,
   output logic [TAG_W-1:0]    rsp_tag_o,
   output logic                rsp_timeout_o,

   // Debug view of the control state (IDLE=0, START=1, WAIT=2, RESP=3)
   output logic [1:0]          dbg_state_o
);

   localparam int EXP_W = fp_exp_width(FP_FORMAT);
   localparam int MAN_W = FP_WIDTH - 1 - EXP_W;
   localparam int CNT_W = 10;

   // Canonical quiet NaN: positive sign, all-ones exponent, mantissa MSB set
   localparam logic [FP_WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic                ready_q, ready_d;
   logic                start_q, start_d;
   logic                valid_q, valid_d;
   logic                timeout_q, timeout_d;
   logic [FP_WIDTH-1:0] a_q, a_d;
   logic [FP_WIDTH-1:0] b_q, b_d;
   roundmode_e          rnd_q, rnd_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [FP_WIDTH-1:0] result_q, result_d;
   status_t             flags_q, flags_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // Next-state and next-payload logic; all outputs are registered from these
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      rnd_d     = rnd_q;
      tag_d     = tag_q;
      result_d  = result_q;
      flags_d   = flags_q;
      timeout_d = timeout_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            // ready_q is only high in IDLE, so this is the accept condition
            if (req_valid_i && ready_q) begin
               a_d     = req_a_i;
               b_d     = req_b_i;
               rnd_d   = req_rnd_i;
               tag_d   = req_tag_i;
               state_d = S_START;
            end
         end
         S_START: begin
            // A done seen here belongs to nobody and is ignored
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (div_done_i) begin
               // Done wins over a simultaneous timeout
               result_d  = div_result_i;
               flags_d   = div_flags_i;
               timeout_d = 1'b0;
               state_d   = S_RESP;
            end else if (cnt_q == TIMEOUT_LAST) begin
               result_d  = QNAN;
               flags_d   = '{nv: 1'b1, default: 1'b0};
               timeout_d = 1'b1;
               state_d   = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered handshake/strobe outputs follow the upcoming state, so
      // ready rises the cycle after a response handshake, never during it
      ready_d = (state_d == S_IDLE);
      start_d = (state_d == S_START);
      valid_d = (state_d == S_RESP);
   end

   // State and datapath registers with asynchronous active-low clear
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= S_IDLE;
         ready_q   <= 1'b0;
         start_q   <= 1'b0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         rnd_q     <= RNE;
         tag_q     <= '0;
         result_q  <= '0;
         flags_q   <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         start_q   <= start_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rnd_q     <= rnd_d;
         tag_q     <= tag_d;
         result_q  <= result_d;
         flags_q   <= flags_d;
         cnt_q     <= cnt_d;
      end
   end

   assign req_ready_o   = ready_q;
   assign div_a_o       = a_q;
   assign div_b_o       = b_q;
   assign div_rnd_o     = rnd_q;
   assign div_start_o   = start_q;
   assign rsp_valid_o   = valid_q;
   assign rsp_result_o  = result_q;
   assign rsp_flags_o   = flags_q;
   assign rsp_tag_o     = tag_q;
   assign rsp_timeout_o = timeout_q;
   assign dbg_state_o   = state_q;

endmodule
